// File: rtl/pwm_bank_ctrl.sv
// N-channel PWM bank controlled by a byte command stream from an rx FIFO.
// Readback bytes go to a tx FIFO. Duty updates land in a shadow register and
// are copied to the active set only when the PWM counter wraps, so a new duty
// never produces a runt or stretched pulse mid-period.
module pwm_bank_ctrl #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rempty,
    input  logic [7:0]        rx_rdata,
    output logic              rx_rinc,
    input  logic              tx_wfull,
    output logic [7:0]        tx_wdata,
    output logic              tx_winc,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              busy,
    output logic              cmd_err
);

    localparam int unsigned DUTY_BYTES = (PWM_WIDTH + 7) / 8;
    localparam int unsigned BUF_W      = 8 * DUTY_BYTES;
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned TO_W       = $clog2(TIMEOUT + 1);

    localparam logic [7:0] OpSetDuty = 8'h50;
    localparam logic [7:0] OpGetDuty = 8'h51;
    localparam logic [7:0] OpSetEn   = 8'h52;
    localparam logic [7:0] OpGetEn   = 8'h53;

    typedef enum logic [2:0] {StIdle, StOpc, StArg, StPay, StExec, StTx} state_e;

    state_e                state_q, state_d;
    logic [7:0]            opcode_q;
    logic [7:0]            arg_q;
    logic [BUF_W-1:0]      pay_q;
    logic [1:0]            pay_cnt_q;
    logic [TO_W-1:0]       tmo_q;
    logic [BUF_W-1:0]      tx_buf_q;
    logic [1:0]            tx_cnt_q;
    logic [PWM_WIDTH-1:0]  duty_shd_q [NUM_CH];
    logic [PWM_WIDTH-1:0]  duty_act_q [NUM_CH];
    logic [NUM_CH-1:0]     en_mask_q;
    logic [PS_W-1:0]       presc_q;
    logic [PWM_WIDTH-1:0]  cnt_q;
    logic [NUM_CH-1:0]     pwm_q;

    logic            rx_avail;
    logic            opc_known;
    logic            ch_ok;
    logic [CH_W-1:0] ch_idx;
    logic            tmo_hit;
    logic            pay_last;
    logic            tx_load;
    logic            tick;
    logic            wrap;

    // Shared decode terms for the FSM and the datapath
    always_comb begin
        rx_avail  = !rx_rempty;
        opc_known = (opcode_q == OpSetDuty) || (opcode_q == OpGetDuty) ||
                    (opcode_q == OpSetEn)   || (opcode_q == OpGetEn);
        ch_ok     = (arg_q < 8'(NUM_CH));
        ch_idx    = arg_q[CH_W-1:0];
        tmo_hit   = (tmo_q == TO_W'(TIMEOUT - 1));
        pay_last  = (pay_cnt_q == 2'(DUTY_BYTES - 1));
        tx_load   = (opcode_q == OpGetEn) || ((opcode_q == OpGetDuty) && ch_ok);
        tick      = (presc_q == PS_W'(PRESCALE - 1));
        wrap      = tick && (cnt_q == '1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rx_avail) state_d = StOpc;
            StOpc: begin
                if (opcode_q == OpGetEn) state_d = StExec;
                else if (opc_known)      state_d = StArg;
                else                     state_d = StIdle;
            end
            StArg: begin
                if (rx_avail)     state_d = (opcode_q == OpSetDuty) ? StPay : StExec;
                else if (tmo_hit) state_d = StIdle;
            end
            StPay: begin
                if (rx_avail) begin
                    if (pay_last) state_d = StExec;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StExec: state_d = tx_load ? StTx : StIdle;
            StTx:   if (!tx_wfull && (tx_cnt_q == 2'd1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; everything held low while reset is asserted
    always_comb begin
        rx_rinc  = 1'b0;
        tx_winc  = 1'b0;
        tx_wdata = 8'h00;
        cmd_err  = 1'b0;
        busy     = !rst && (state_q != StIdle);
        if (!rst) begin
            unique case (state_q)
                StIdle: rx_rinc = rx_avail;
                StOpc:  cmd_err = !opc_known;
                StArg, StPay: begin
                    rx_rinc = rx_avail;
                    cmd_err = !rx_avail && tmo_hit;
                end
                StExec: cmd_err = ((opcode_q == OpSetDuty) || (opcode_q == OpGetDuty)) && !ch_ok;
                StTx: begin
                    tx_winc  = !tx_wfull;
                    tx_wdata = tx_wfull ? 8'h00 : tx_buf_q[BUF_W-1 -: 8];
                end
                default: ;
            endcase
        end
    end

    // Command datapath: byte capture, timeout, register writes, readback buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= 8'h00;
            arg_q      <= 8'h00;
            pay_q      <= '0;
            pay_cnt_q  <= 2'd0;
            tmo_q      <= '0;
            tx_buf_q   <= '0;
            tx_cnt_q   <= 2'd0;
            duty_shd_q <= '{default: '0};
            en_mask_q  <= '0;
        end else begin
            // Counts idle cycles while waiting on a payload byte; any pop restarts it
            if (((state_q == StArg) || (state_q == StPay)) && !rx_avail) begin
                tmo_q <= tmo_q + TO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            unique case (state_q)
                StIdle: if (rx_avail) opcode_q <= rx_rdata;
                StArg: begin
                    if (rx_avail) begin
                        arg_q     <= rx_rdata;
                        pay_q     <= '0;
                        pay_cnt_q <= 2'd0;
                    end
                end
                StPay: begin
                    if (rx_avail) begin
                        pay_q     <= (pay_q << 8) | BUF_W'(rx_rdata);
                        pay_cnt_q <= pay_cnt_q + 2'd1;
                    end
                end
                StExec: begin
                    unique case (opcode_q)
                        OpSetDuty: if (ch_ok) duty_shd_q[ch_idx] <= pay_q[PWM_WIDTH-1:0];
                        OpGetDuty: begin
                            if (ch_ok) begin
                                tx_buf_q <= BUF_W'(duty_shd_q[ch_idx]);
                                tx_cnt_q <= 2'(DUTY_BYTES);
                            end
                        end
                        OpSetEn: en_mask_q <= arg_q[NUM_CH-1:0];
                        OpGetEn: begin
                            tx_buf_q <= BUF_W'(en_mask_q) << (BUF_W - 8);
                            tx_cnt_q <= 2'd1;
                        end
                        default: ;
                    endcase
                end
                StTx: begin
                    if (!tx_wfull) begin
                        tx_buf_q <= tx_buf_q << 8;
                        tx_cnt_q <= tx_cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PWM timebase, wrap-synchronous duty transfer and registered compare
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            duty_act_q <= '{default: '0};
            pwm_q      <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PS_W'(1);
            if (tick) cnt_q <= cnt_q + PWM_WIDTH'(1);
            if (wrap) duty_act_q <= duty_shd_q;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= en_mask_q[i] && (cnt_q < duty_act_q[i]);
            end
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Directed bench for pwm_bank_ctrl: an 8-bit instance (TIMEOUT=100) and a
// 12-bit instance, each fed from a queue-modelled rx FIFO with tx capture.
module tb_pwm_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tx_wfull;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A: 4 ch, 8 bit, timeout 100 ----------------
    logic       rx_rempty_a = 1'b1;
    logic [7:0] rx_rdata_a  = 8'h00;
    logic       rx_rinc_a, tx_winc_a, busy_a, cmd_err_a;
    logic [7:0] tx_wdata_a;
    logic [3:0] pwm_out_a;

    pwm_bank_ctrl #(.NUM_CH(4), .PWM_WIDTH(8), .PRESCALE(1), .TIMEOUT(100)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx_rempty (rx_rempty_a),
        .rx_rdata  (rx_rdata_a),
        .rx_rinc   (rx_rinc_a),
        .tx_wfull  (tx_wfull),
        .tx_wdata  (tx_wdata_a),
        .tx_winc   (tx_winc_a),
        .pwm_out   (pwm_out_a),
        .busy      (busy_a),
        .cmd_err   (cmd_err_a)
    );

    // ---------------- instance B: 4 ch, 12 bit ----------------
    logic       rx_rempty_b = 1'b1;
    logic [7:0] rx_rdata_b  = 8'h00;
    logic       rx_rinc_b, tx_winc_b, busy_b, cmd_err_b;
    logic [7:0] tx_wdata_b;
    logic [3:0] pwm_out_b;

    pwm_bank_ctrl #(.NUM_CH(4), .PWM_WIDTH(12), .PRESCALE(1), .TIMEOUT(65535)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx_rempty (rx_rempty_b),
        .rx_rdata  (rx_rdata_b),
        .rx_rinc   (rx_rinc_b),
        .tx_wfull  (tx_wfull),
        .tx_wdata  (tx_wdata_b),
        .tx_winc   (tx_winc_b),
        .pwm_out   (pwm_out_b),
        .busy      (busy_b),
        .cmd_err   (cmd_err_b)
    );

    // ---------------- FIFO models and monitors ----------------
    logic [7:0] rxq_a [$];
    logic [7:0] rxq_b [$];
    logic [7:0] txq_a [$];
    logic [7:0] txq_b [$];

    int cyc = 0;
    int err_a = 0, err_b = 0;
    int last_pop_a = 0, last_err_a = 0;
    int rinc_viol = 0, wfull_viol = 0;
    logic [7:0]  mcnt_a;
    logic [11:0] mcnt_b;
    int hi_cnt [4];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rinc_a) begin
            last_pop_a <= cyc;
            if (rxq_a.size() == 0) rinc_viol <= rinc_viol + 1;
            else void'(rxq_a.pop_front());
        end
        if (rx_rinc_b) begin
            if (rxq_b.size() == 0) rinc_viol <= rinc_viol + 1;
            else void'(rxq_b.pop_front());
        end
        if (tx_winc_a) begin
            txq_a.push_back(tx_wdata_a);
            if (tx_wfull) wfull_viol <= wfull_viol + 1;
        end
        if (tx_winc_b) begin
            txq_b.push_back(tx_wdata_b);
            if (tx_wfull) wfull_viol <= wfull_viol + 1;
        end
        if (cmd_err_a) begin
            err_a      <= err_a + 1;
            last_err_a <= cyc;
        end
        if (cmd_err_b) err_b <= err_b + 1;
        // Reference PWM counters, free-running from reset release
        mcnt_a <= rst ? 8'd0 : mcnt_a + 8'd1;
        mcnt_b <= rst ? 12'd0 : mcnt_b + 12'd1;
    end

    // Present the FIFO head mid-cycle so it is stable at the next rising edge
    always @(negedge clk) begin
        rx_rempty_a <= (rxq_a.size() == 0);
        rx_rdata_a  <= (rxq_a.size() != 0) ? rxq_a[0] : 8'h00;
        rx_rempty_b <= (rxq_b.size() == 0);
        rx_rdata_b  <= (rxq_b.size() != 0) ? rxq_b[0] : 8'h00;
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] b);
        if (sel) rxq_b.push_back(b);
        else     rxq_a.push_back(b);
    endtask

    task automatic wait_idle(input bit sel);
        int n;
        n = 0;
        while ((((sel ? rxq_b.size() : rxq_a.size()) != 0) || (sel ? busy_b : busy_a)) && n < 2000)
        begin
            tick_n(1);
            n++;
        end
        tick_n(1);
        check_eq("idle_wait", 32'(n < 2000), 32'd1);
    endtask

    // val carries n bytes, first-pushed byte most significant
    task automatic expect_tx(input bit sel, input string tag, input int n, input logic [15:0] val);
        int sz;
        logic [7:0] got;
        logic [7:0] exp;
        sz = sel ? txq_b.size() : txq_a.size();
        check_eq({tag, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            got = sel ? txq_b[i] : txq_a[i];
            exp = 8'(val >> (8 * (n - 1 - i)));
            check_eq({tag, "_byte"}, 32'(got), 32'(exp));
        end
        if (sel) txq_b.delete();
        else     txq_a.delete();
    endtask

    task automatic sync_wrap(input bit sel);
        int n;
        n = 0;
        while (((sel ? mcnt_b : 12'(mcnt_a)) != 12'd1) && n < 5000) begin
            tick_n(1);
            n++;
        end
        check_eq("wrap_sync", 32'(n < 5000), 32'd1);
    endtask

    // Samples one full period starting at reference count 1 (output for cnt 0)
    task automatic count_period(input bit sel);
        int len;
        len = sel ? 4096 : 256;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (sel ? pwm_out_b[c] : pwm_out_a[c]) hi_cnt[c]++;
            end
            tick_n(1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e0;
        int n;
        rst      = 1'b1;
        tx_wfull = 1'b0;
        // Byte queued during reset must stay in the FIFO until reset drops
        push(0, 8'h53);
        tick_n(3);
        check_eq("rst_pwm", 32'(pwm_out_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_err", 32'(cmd_err_a), 32'd0);
        check_eq("rst_rinc", 32'(rx_rinc_a), 32'd0);
        check_eq("rst_winc", 32'(tx_winc_a), 32'd0);
        check_eq("rst_fifo_kept", 32'(rxq_a.size()), 32'd1);
        rst = 1'b0;
        wait_idle(0);
        expect_tx(0, "rst_en", 1, 16'h0000);

        // T1: ch2=0x40, ch1=0x20, mask 0F
        push(0, 8'h50); push(0, 8'h02); push(0, 8'h40);
        push(0, 8'h52); push(0, 8'h0F);
        push(0, 8'h50); push(0, 8'h01); push(0, 8'h20);
        wait_idle(0);
        sync_wrap(0);
        count_period(0);
        check_eq("t1_ch0", 32'(hi_cnt[0]), 32'd0);
        check_eq("t1_ch1", 32'(hi_cnt[1]), 32'd32);
        check_eq("t1_ch2", 32'(hi_cnt[2]), 32'd64);
        check_eq("t1_ch3", 32'(hi_cnt[3]), 32'd0);
        push(0, 8'h53);
        wait_idle(0);
        expect_tx(0, "t1_get_en", 1, 16'h000F);
        push(0, 8'h51); push(0, 8'h02);
        wait_idle(0);
        expect_tx(0, "t1_get_duty", 1, 16'h0040);

        // T2: mid-period write of ch1 must not touch the running period
        sync_wrap(0);
        fork
            count_period(0);
            begin
                tick_n(100);
                push(0, 8'h50); push(0, 8'h01); push(0, 8'h80);
            end
        join
        check_eq("t2_old_period", 32'(hi_cnt[1]), 32'd32);
        count_period(0);
        check_eq("t2_new_period", 32'(hi_cnt[1]), 32'd128);
        check_eq("t2_ch2_steady", 32'(hi_cnt[2]), 32'd64);

        // T3: readback held off by a full tx FIFO
        tx_wfull = 1'b1;
        push(0, 8'h51); push(0, 8'h02);
        tick_n(20);
        check_eq("t3_no_push", 32'(txq_a.size()), 32'd0);
        check_eq("t3_busy", 32'(busy_a), 32'd1);
        tx_wfull = 1'b0;
        wait_idle(0);
        expect_tx(0, "t3_get", 1, 16'h0040);

        // T4: bad channel, unknown opcode, bad GET channel
        e0 = err_a;
        push(0, 8'h50); push(0, 8'h07); push(0, 8'h33);
        wait_idle(0);
        check_eq("t4_badch_err", 32'(err_a - e0), 32'd1);
        check_eq("t4_consumed", 32'(rxq_a.size()), 32'd0);
        push(0, 8'h51); push(0, 8'h03);
        wait_idle(0);
        expect_tx(0, "t4_ch3_unchanged", 1, 16'h0000);
        e0 = err_a;
        push(0, 8'hAA); push(0, 8'h53);
        wait_idle(0);
        check_eq("t4_badop_err", 32'(err_a - e0), 32'd1);
        expect_tx(0, "t4_after_badop", 1, 16'h000F);
        e0 = err_a;
        push(0, 8'h51); push(0, 8'h05);
        wait_idle(0);
        check_eq("t4_badget_err", 32'(err_a - e0), 32'd1);
        expect_tx(0, "t4_badget", 0, 16'h0000);

        // T5: payload never arrives
        e0 = err_a;
        push(0, 8'h50); push(0, 8'h01);
        n = 0;
        while (err_a == e0 && n < 400) begin
            tick_n(1);
            n++;
        end
        check_eq("t5_err_seen", 32'(err_a - e0), 32'd1);
        check_eq("t5_latency", 32'(last_err_a - last_pop_a), 32'd100);
        check_eq("t5_idle", 32'(busy_a), 32'd0);
        push(0, 8'h53);
        wait_idle(0);
        expect_tx(0, "t5_get_en", 1, 16'h000F);
        push(0, 8'h51); push(0, 8'h01);
        wait_idle(0);
        expect_tx(0, "t5_duty_kept", 1, 16'h0080);

        // T6: 12-bit duty, unused MSBs dropped, two-byte readback
        push(1, 8'h50); push(1, 8'h00); push(1, 8'h0A); push(1, 8'hBC);
        push(1, 8'h52); push(1, 8'h01);
        push(1, 8'h51); push(1, 8'h00);
        wait_idle(1);
        expect_tx(1, "t6_get", 2, 16'h0ABC);
        push(1, 8'h50); push(1, 8'h00); push(1, 8'hFA); push(1, 8'hBC);
        push(1, 8'h51); push(1, 8'h00);
        wait_idle(1);
        expect_tx(1, "t6_msb_masked", 2, 16'h0ABC);
        check_eq("t6_no_err", 32'(err_b), 32'd0);
        sync_wrap(1);
        count_period(1);
        check_eq("t6_ch0_high", 32'(hi_cnt[0]), 32'd2748);
        check_eq("t6_ch1_low", 32'(hi_cnt[1]), 32'd0);

        // Reset during a stalled readback: no bytes may leak afterwards
        tx_wfull = 1'b1;
        push(1, 8'h51); push(1, 8'h00);
        tick_n(5);
        check_eq("t6_stalled_busy", 32'(busy_b), 32'd1);
        rst = 1'b1;
        push(1, 8'h53);
        tick_n(3);
        tx_wfull = 1'b0;
        check_eq("t6_rst_pwm", 32'(pwm_out_b), 32'd0);
        check_eq("t6_rst_busy", 32'(busy_b), 32'd0);
        check_eq("t6_rst_winc", 32'(tx_winc_b), 32'd0);
        check_eq("t6_rst_rinc", 32'(rx_rinc_b), 32'd0);
        check_eq("t6_rst_fifo_kept", 32'(rxq_b.size()), 32'd1);
        rst = 1'b0;
        wait_idle(1);
        expect_tx(1, "t6_after_rst", 1, 16'h0000);

        // Reset mid-payload: partial SET_DUTY must not write
        push(1, 8'h50); push(1, 8'h01); push(1, 8'h0F);
        tick_n(6);
        check_eq("t6_mid_pay_busy", 32'(busy_b), 32'd1);
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        check_eq("t6_mid_pay_idle", 32'(busy_b), 32'd0);
        push(1, 8'h51); push(1, 8'h01);
        wait_idle(1);
        expect_tx(1, "t6_no_partial", 2, 16'h0000);

        check_eq("rinc_when_empty", 32'(rinc_viol), 32'd0);
        check_eq("winc_when_full", 32'(wfull_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
